// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads the icache combinationally and queues {pc, instr} toward decode.
// Head is registered (fetch at N visible at N+1); full queue without a pop holds the PC in place.

// Generic flushable FIFO; head is presented from storage and reads zero when empty.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: the caller must not push when full unless it pops in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       vld,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  assign vld   = (count != '0);
  assign full  = (count == DEPTH_C);
  assign rdata = vld ? mem[head] : '0;

  // Storage is written only on push; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Instruction fetch: PC register, icache address drive, fetch queue to decode.
// Latency: one cycle from icache read to queue head; no bypass path.
// Backpressure: out_ready low fills the queue, then pc holds on the un-fetched address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  output logic [31:0]                 icache_addr,
  input  logic [31:0]                 icache_data,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output logic [31:0]                 out_instr,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  logic [31:0] pc;
  logic        pop;
  logic        push;
  logic        fq_full;
  fq_entry_t   wr_entry;
  fq_entry_t   head_entry;

  // Redirect suppresses both ends of the queue so no stale entry slips out or in.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & (~fq_full | pop);

  assign icache_addr    = pc;
  assign wr_entry.pc    = pc;
  assign wr_entry.instr = icache_data;
  assign out_pc         = head_entry.pc;
  assign out_instr      = head_entry.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_entry),
    .vld   (out_valid),
    .full  (fq_full),
    .count (fq_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random stimulus against a queue-based scoreboard of {pc, instr} pairs.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fq_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign icache_data = instr_of(icache_addr);

  fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .icache_addr    (icache_addr),
    .icache_data    (icache_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fq_count       (fq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fq_count", 64'(fq_count), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("icache_addr", 64'(icache_addr), 64'(mpc));
    if (mq.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0][63:32]));
      chk("out_instr", 64'(out_instr), 64'(mq[0][31:0]));
    end else begin
      chk("empty_pc", 64'(out_pc), 64'd0);
      chk("empty_instr", 64'(out_instr), 64'd0);
    end
  endtask

  // Advance the model with the inputs currently driven, clock once, then compare.
  task automatic tick();
    bit m_pop, m_push;
    m_pop  = (mq.size() != 0) && out_ready && !redirect_valid;
    m_push = fetch_en && !redirect_valid && ((mq.size() < DEPTH) || m_pop);
    if (rst) begin
      mq.delete();
      mpc = RPC;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({mpc, instr_of(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    mpc = RPC;
    tick();
    tick();
    chk("rst_addr", 64'(icache_addr), 64'h100);
    chk("rst_valid", 64'(out_valid), 64'd0);

    // 1: streaming from reset
    rst = 1'b0; redirect_valid = 1'b0;
    tick();
    chk("t1_pc0", 64'(out_pc), 64'h100);
    chk("t1_instr0", 64'(out_instr), 64'(instr_of(32'h100)));
    tick();
    chk("t1_pc1", 64'(out_pc), 64'h104);
    tick();
    chk("t1_pc2", 64'(out_pc), 64'h108);
    for (int i = 0; i < 5; i++) tick();

    // 2: fill, hold, then drain at full rate
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_full_cnt", 64'(fq_count), 64'd4);
    chk("t2_full_addr", 64'(icache_addr), 64'h110);
    tick(); tick();
    chk("t2_hold_addr", 64'(icache_addr), 64'h110);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_sustain_cnt", 64'(fq_count), 64'd4);

    // 3: redirect with 3 queued entries
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; out_ready = 1'b0; tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_pre_cnt", 64'(fq_count), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; tick();
    chk("t3_cnt", 64'(fq_count), 64'd0);
    chk("t3_addr", 64'(icache_addr), 64'h200);
    redirect_valid = 1'b0; tick();
    chk("t3_head", 64'(out_pc), 64'h200);

    // 4: redirect beats pop and push in the same cycle
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; out_ready = 1'b1; tick();
    chk("t4_cnt", 64'(fq_count), 64'd0);
    chk("t4_addr", 64'(icache_addr), 64'h400);
    redirect_valid = 1'b0; tick();

    // 5: PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; tick();
    chk("t5_addr", 64'(icache_addr), 64'hFFFF_FFFC);
    redirect_valid = 1'b0; tick();
    chk("t5_head", 64'(out_pc), 64'hFFFF_FFFC);
    chk("t5_wrap", 64'(icache_addr), 64'h0);
    tick();
    chk("t5_head2", 64'(out_pc), 64'h0);

    // 6: reset mid-stream
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0800; tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_pre_cnt", 64'(fq_count), 64'd3);
    rst = 1'b1; redirect_valid = 1'b1; tick();
    chk("t6_cnt", 64'(fq_count), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_addr", 64'(icache_addr), 64'h100);
    rst = 1'b0; redirect_valid = 1'b0;

    // Random traffic with occasional redirects and fetch stalls
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
